// File: rtl/ee194_core_top.sv
`timescale 1ns/1ps
// ee194_core_top: reduced BLE-radio test top. GFSK self-test (pattern TX as frequency codes,
// zero-crossing demod of returned I/Q, pass/fail on GPIO), IDCODE/BYPASS JTAG TAP, idle UART/scan.
module ee194_core_top (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_jtag_TCK,
  input  logic       io_jtag_TMS,
  input  logic       io_jtag_TDI,
  input  logic       io_jtag_TRSTn,
  output logic       io_jtag_TDO,
  input  logic       io_uart_rxd,
  output logic       io_uart_txd,
  output logic [2:0] io_gfskout,
  input  logic [4:0] io_isig,
  input  logic [4:0] io_qsig,
  input  logic       io_clock_40MHz,
  input  logic       io_scanchain_PHI,
  input  logic       io_scanchain_PHIB,
  input  logic       io_scanchain_i0o1,
  input  logic       io_scanchain_LOAD,
  input  logic       io_scanchain_SCAN_IN,
  output logic       io_scanchain_SCAN_OUT,
  input  logic       io_gpio_pins_0_i_ival,
  input  logic       io_gpio_pins_1_i_ival,
  input  logic       io_gpio_pins_2_i_ival,
  input  logic       io_gpio_pins_3_i_ival,
  input  logic       io_enable_scan_global,
  input  logic       io_alternate_modulation_in,
  input  logic       io_modulator_bypass_force,
  output logic       io_gpio_pins_1_o_oval,
  output logic       io_gpio_pins_2_o_oval
);

  localparam logic [31:0] PATTERN     = 32'hA5C3_0F96;
  localparam logic [31:0] IDCODE      = 32'h0000_194B;
  localparam int unsigned NBITS       = 32;
  localparam int unsigned BIT_CYCLES  = 64;
  localparam int unsigned START_DELAY = 100;
  localparam int unsigned RAMP_CYCLES = 2;
  localparam int unsigned XING_THRESH = 32;
  localparam int unsigned ERR_MAX     = 2;
  localparam int unsigned BIT_W       = $clog2(NBITS);
  localparam int unsigned CYC_W       = $clog2(BIT_CYCLES);
  localparam int unsigned WAIT_W      = $clog2(START_DELAY);
  localparam int unsigned RAMP_W      = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int unsigned XCNT_W      = 7;
  localparam int unsigned ERR_W       = 6;
  localparam logic [3:0]  IR_IDCODE   = 4'b0001;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_TX, S_FINISH, S_DONE} gfsk_state_e;

  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUSEDR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUSEIR, T_EX2IR, T_UPIR
  } tap_state_e;

  gfsk_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic [2:0]        level_q, level_d;
  logic [2:0]        gfsk_q, gfsk_d;
  logic [XCNT_W-1:0] xcnt_q, xcnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              status_q, status_d;
  logic              done_q, done_d;
  logic              sign_q, sign_prev_q;
  logic [4:0]        qsig_q;
  logic              xing_c, decoded_c;
  logic [XCNT_W-1:0] xsum_c;
  logic [2:0]        target_c;

  tap_state_e        tap_q, tap_d;
  logic [3:0]        ir_q, ir_d, irsh_q, irsh_d;
  logic [31:0]       dr_q, dr_d;
  logic              byp_q, byp_d;
  logic              tdo_q, tdo_d;
  logic              tck_q;
  logic              tck_rise_c, tck_fall_c, byp_sel_c;

  // Self-test sequencer, TX ramp shaping and window decoder
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bit_d     = bit_q;
    cyc_d     = cyc_q;
    ramp_d    = ramp_q;
    level_d   = level_q;
    xcnt_d    = xcnt_q;
    err_d     = err_q;
    status_d  = status_q;
    done_d    = done_q;
    target_c  = 3'd1;
    decoded_c = 1'b0;
    xing_c    = sign_q ^ sign_prev_q;
    xsum_c    = (&xcnt_q) ? xcnt_q : xcnt_q + XCNT_W'(xing_c);
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(START_DELAY - 2)) begin
          state_d = S_TX;
          bit_d   = '0;
          cyc_d   = '0;
          ramp_d  = '0;
          level_d = 3'd1;
          xcnt_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_TX: begin
        cyc_d  = cyc_q + CYC_W'(1);
        xcnt_d = xsum_c;
        if (cyc_q == CYC_W'(BIT_CYCLES - 1)) begin
          decoded_c = (xsum_c >= XCNT_W'(XING_THRESH));
          cyc_d     = '0;
          xcnt_d    = '0;
          bit_d     = bit_q + BIT_W'(1);
          if ((decoded_c != PATTERN[BIT_W'(NBITS - 1) - bit_q]) && !(&err_q))
            err_d = err_q + ERR_W'(1);
        end
        // target follows the window being entered so the ramp starts on the boundary
        target_c = PATTERN[BIT_W'(NBITS - 1) - bit_d] ? 3'd7 : 3'd1;
        if (ramp_q == RAMP_W'(RAMP_CYCLES - 1)) begin
          ramp_d = '0;
          if (level_q < target_c)      level_d = level_q + 3'd1;
          else if (level_q > target_c) level_d = level_q - 3'd1;
        end else begin
          ramp_d = ramp_q + RAMP_W'(1);
        end
        if ((cyc_q == CYC_W'(BIT_CYCLES - 1)) && (bit_q == BIT_W'(NBITS - 1))) begin
          state_d = S_FINISH;
          level_d = 3'd0;
        end
      end
      S_FINISH: begin
        status_d = (err_q <= ERR_W'(ERR_MAX));
        state_d  = S_DONE;
      end
      S_DONE: done_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
    gfsk_d = io_modulator_bypass_force ? (io_alternate_modulation_in ? 3'd7 : 3'd1) : level_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      bit_q       <= '0;
      cyc_q       <= '0;
      ramp_q      <= '0;
      level_q     <= 3'd0;
      gfsk_q      <= 3'd0;
      xcnt_q      <= '0;
      err_q       <= '0;
      status_q    <= 1'b0;
      done_q      <= 1'b0;
      sign_q      <= 1'b0;
      sign_prev_q <= 1'b0;
      qsig_q      <= 5'd0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bit_q       <= bit_d;
      cyc_q       <= cyc_d;
      ramp_q      <= ramp_d;
      level_q     <= level_d;
      gfsk_q      <= gfsk_d;
      xcnt_q      <= xcnt_d;
      err_q       <= err_d;
      status_q    <= status_d;
      done_q      <= done_d;
      sign_q      <= (io_isig >= 5'd16);
      sign_prev_q <= sign_q;
      qsig_q      <= io_qsig;
    end
  end

  // JTAG TAP, advanced on TCK edges detected in the system clock domain
  always_comb begin
    tck_rise_c = io_jtag_TCK & ~tck_q;
    tck_fall_c = ~io_jtag_TCK & tck_q;
    byp_sel_c  = (ir_q != IR_IDCODE);
    tap_d      = tap_q;
    ir_d       = ir_q;
    irsh_d     = irsh_q;
    dr_d       = dr_q;
    byp_d      = byp_q;
    tdo_d      = tdo_q;
    if (tck_rise_c) begin
      case (tap_q)
        T_TLR:     tap_d = io_jtag_TMS ? T_TLR   : T_RTI;
        T_RTI:     tap_d = io_jtag_TMS ? T_SELDR : T_RTI;
        T_SELDR:   tap_d = io_jtag_TMS ? T_SELIR : T_CAPDR;
        T_CAPDR: begin
          tap_d = io_jtag_TMS ? T_EX1DR : T_SHDR;
          dr_d  = byp_sel_c ? 32'h0 : IDCODE;
          byp_d = 1'b0;
        end
        T_SHDR: begin
          tap_d = io_jtag_TMS ? T_EX1DR : T_SHDR;
          if (byp_sel_c) byp_d = io_jtag_TDI;
          else           dr_d  = {io_jtag_TDI, dr_q[31:1]};
        end
        T_EX1DR:   tap_d = io_jtag_TMS ? T_UPDR  : T_PAUSEDR;
        T_PAUSEDR: tap_d = io_jtag_TMS ? T_EX2DR : T_PAUSEDR;
        T_EX2DR:   tap_d = io_jtag_TMS ? T_UPDR  : T_SHDR;
        T_UPDR:    tap_d = io_jtag_TMS ? T_SELDR : T_RTI;
        T_SELIR:   tap_d = io_jtag_TMS ? T_TLR   : T_CAPIR;
        T_CAPIR: begin
          tap_d  = io_jtag_TMS ? T_EX1IR : T_SHIR;
          irsh_d = 4'b0001;
        end
        T_SHIR: begin
          tap_d  = io_jtag_TMS ? T_EX1IR : T_SHIR;
          irsh_d = {io_jtag_TDI, irsh_q[3:1]};
        end
        T_EX1IR:   tap_d = io_jtag_TMS ? T_UPIR  : T_PAUSEIR;
        T_PAUSEIR: tap_d = io_jtag_TMS ? T_EX2IR : T_PAUSEIR;
        T_EX2IR:   tap_d = io_jtag_TMS ? T_UPIR  : T_SHIR;
        T_UPIR: begin
          tap_d = io_jtag_TMS ? T_SELDR : T_RTI;
          ir_d  = irsh_q;
        end
        default:   tap_d = T_TLR;
      endcase
    end
    if (tck_fall_c) begin
      if (tap_q == T_SHDR)      tdo_d = byp_sel_c ? byp_q : dr_q[0];
      else if (tap_q == T_SHIR) tdo_d = irsh_q[0];
      else                      tdo_d = 1'b0;
    end
    if (tap_q == T_TLR) ir_d = IR_IDCODE;
    if (!io_jtag_TRSTn) begin
      tap_d = T_TLR;
      ir_d  = IR_IDCODE;
      tdo_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tap_q  <= T_TLR;
      ir_q   <= IR_IDCODE;
      irsh_q <= 4'd0;
      dr_q   <= 32'd0;
      byp_q  <= 1'b0;
      tdo_q  <= 1'b0;
      tck_q  <= 1'b0;
    end else begin
      tap_q  <= tap_d;
      ir_q   <= ir_d;
      irsh_q <= irsh_d;
      dr_q   <= dr_d;
      byp_q  <= byp_d;
      tdo_q  <= tdo_d;
      tck_q  <= io_jtag_TCK;
    end
  end

  assign io_gfskout            = gfsk_q;
  assign io_gpio_pins_1_o_oval = status_q;
  assign io_gpio_pins_2_o_oval = done_q;
  assign io_jtag_TDO           = tdo_q;
  assign io_uart_txd           = 1'b1;
  assign io_scanchain_SCAN_OUT = 1'b0;

  // Inputs present for pin compatibility only; Q samples are reserved
  logic unused_inputs;
  assign unused_inputs = ^{io_uart_rxd, io_clock_40MHz, io_scanchain_PHI, io_scanchain_PHIB,
                           io_scanchain_i0o1, io_scanchain_LOAD, io_scanchain_SCAN_IN,
                           io_gpio_pins_0_i_ival, io_gpio_pins_1_i_ival, io_gpio_pins_2_i_ival,
                           io_gpio_pins_3_i_ival, io_enable_scan_global, qsig_q};

endmodule

// File: tb/tb_ee194_core_top.sv
`timescale 1ns/1ps
// Directed bench for ee194_core_top: self-test timing and pass/fail, error threshold,
// modulator bypass, mid-TX reset, JTAG IDCODE/BYPASS/TRSTn.
module tb_ee194_core_top;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       io_jtag_TCK = 1'b0, io_jtag_TMS = 1'b0, io_jtag_TDI = 1'b0, io_jtag_TRSTn = 1'b1;
  logic       io_jtag_TDO, io_uart_txd, io_scanchain_SCAN_OUT;
  logic       io_gpio_pins_1_o_oval, io_gpio_pins_2_o_oval;
  logic [2:0] io_gfskout;
  logic [4:0] io_isig = 5'd16, io_qsig = 5'd16;
  logic       io_alternate_modulation_in = 1'b0, io_modulator_bypass_force = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rel_cyc  = 0;
  logic        tone_fixed = 1'b0;
  logic [31:0] corrupt   = 32'h0;
  logic [31:0] got;

  always #50 clock = ~clock;

  ee194_core_top dut (
    .clock(clock), .reset(reset),
    .io_jtag_TCK(io_jtag_TCK), .io_jtag_TMS(io_jtag_TMS), .io_jtag_TDI(io_jtag_TDI),
    .io_jtag_TRSTn(io_jtag_TRSTn), .io_jtag_TDO(io_jtag_TDO),
    .io_uart_rxd(1'b1), .io_uart_txd(io_uart_txd),
    .io_gfskout(io_gfskout), .io_isig(io_isig), .io_qsig(io_qsig),
    .io_clock_40MHz(1'b0),
    .io_scanchain_PHI(1'b0), .io_scanchain_PHIB(1'b0), .io_scanchain_i0o1(1'b0),
    .io_scanchain_LOAD(1'b0), .io_scanchain_SCAN_IN(1'b0),
    .io_scanchain_SCAN_OUT(io_scanchain_SCAN_OUT),
    .io_gpio_pins_0_i_ival(1'b0), .io_gpio_pins_1_i_ival(1'b0),
    .io_gpio_pins_2_i_ival(1'b0), .io_gpio_pins_3_i_ival(1'b0),
    .io_enable_scan_global(1'b0),
    .io_alternate_modulation_in(io_alternate_modulation_in),
    .io_modulator_bypass_force(io_modulator_bypass_force),
    .io_gpio_pins_1_o_oval(io_gpio_pins_1_o_oval),
    .io_gpio_pins_2_o_oval(io_gpio_pins_2_o_oval)
  );

  // Clock edges since the last reset edge
  initial forever begin
    @(posedge clock);
    if (reset) rel_cyc = 0;
    else       rel_cyc = rel_cyc + 1;
  end

  // Returned tone: sign toggles every cycle for high codes, every 4 cycles otherwise
  initial begin
    logic sgn;
    int   slow;
    int   w;
    logic fast;
    sgn  = 1'b0;
    slow = 0;
    forever begin
      @(negedge clock);
      w = (rel_cyc >= 100) ? (rel_cyc - 100) / 64 : 0;
      if (w > 31) w = 31;
      fast = !tone_fixed && (io_gfskout >= 3'd4) && !corrupt[w];
      if (fast) begin
        sgn  = ~sgn;
        slow = 0;
      end else begin
        slow = slow + 1;
        if (slow >= 4) begin
          sgn  = ~sgn;
          slow = 0;
        end
      end
      io_isig = sgn ? 5'd22 : 5'd9;
      io_qsig = sgn ? 5'd9 : 5'd22;
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (rel_cyc=%0d)", nm, act, exp, rel_cyc);
    end
  endtask

  task automatic wait_rel(input int n);
    int guard;
    guard = 0;
    while (rel_cyc < n && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (rel_cyc != n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_rel: reached %0d expected %0d", rel_cyc, n);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_end(input string nm, input logic exp_status);
    wait_rel(2148);
    chk({nm, "_gfsk_2148"}, 32'(io_gfskout), 32'd0);
    chk({nm, "_done_2148"}, 32'(io_gpio_pins_2_o_oval), 32'd0);
    chk({nm, "_stat_2148"}, 32'(io_gpio_pins_1_o_oval), 32'd0);
    wait_rel(2149);
    chk({nm, "_done_2149"}, 32'(io_gpio_pins_2_o_oval), 32'd0);
    chk({nm, "_stat_2149"}, 32'(io_gpio_pins_1_o_oval), 32'(exp_status));
    wait_rel(2150);
    chk({nm, "_done_2150"}, 32'(io_gpio_pins_2_o_oval), 32'd1);
    chk({nm, "_stat_2150"}, 32'(io_gpio_pins_1_o_oval), 32'(exp_status));
  endtask

  task automatic tck_pulse(input logic tms, input logic tdi);
    io_jtag_TMS = tms;
    io_jtag_TDI = tdi;
    repeat (2) @(negedge clock);
    io_jtag_TCK = 1'b1;
    repeat (3) @(negedge clock);
    io_jtag_TCK = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // TDO read before each pulse; the last pulse carries TMS=1 to leave the shift state
  task automatic shift_read(input int nbits, input logic [31:0] din, output logic [31:0] dout);
    dout = 32'h0;
    for (int i = 0; i < nbits; i++) begin
      dout[i] = io_jtag_TDO;
      tck_pulse(i == nbits - 1, din[i]);
    end
  endtask

  task automatic go_shift_dr();
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
  endtask

  task automatic load_ir_bypass(output logic [31:0] cap);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    tck_pulse(1'b0, 1'b0);
    shift_read(4, 32'hF, cap);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
  endtask

  typedef struct {
    int         n;
    logic [2:0] gfsk;
    logic       done;
    logic       status;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1,    3'd0, 1'b0, 1'b0};
    tbl[1]  = '{99,   3'd0, 1'b0, 1'b0};
    tbl[2]  = '{100,  3'd1, 1'b0, 1'b0};
    tbl[3]  = '{101,  3'd1, 1'b0, 1'b0};
    tbl[4]  = '{102,  3'd2, 1'b0, 1'b0};
    tbl[5]  = '{104,  3'd3, 1'b0, 1'b0};
    tbl[6]  = '{112,  3'd7, 1'b0, 1'b0};
    tbl[7]  = '{163,  3'd7, 1'b0, 1'b0};
    tbl[8]  = '{164,  3'd6, 1'b0, 1'b0};
    tbl[9]  = '{165,  3'd6, 1'b0, 1'b0};
    tbl[10] = '{174,  3'd1, 1'b0, 1'b0};
    tbl[11] = '{2147, 3'd1, 1'b0, 1'b0};
    tbl[12] = '{2148, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{2149, 3'd0, 1'b0, 1'b1};
    tbl[14] = '{2150, 3'd0, 1'b1, 1'b1};
    tbl[15] = '{2300, 3'd0, 1'b1, 1'b1};

    // Reset state, then nominal self-test run
    repeat (10) @(negedge clock);
    chk("rst_gfsk", 32'(io_gfskout), 32'd0);
    chk("rst_done", 32'(io_gpio_pins_2_o_oval), 32'd0);
    chk("rst_status", 32'(io_gpio_pins_1_o_oval), 32'd0);
    chk("rst_tdo", 32'(io_jtag_TDO), 32'd0);
    chk("rst_txd", 32'(io_uart_txd), 32'd1);
    chk("rst_scan_out", 32'(io_scanchain_SCAN_OUT), 32'd0);
    repeat (40) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_rel(tbl[i].n);
      chk($sformatf("run_gfsk@%0d", tbl[i].n), 32'(io_gfskout), 32'(tbl[i].gfsk));
      chk($sformatf("run_done@%0d", tbl[i].n), 32'(io_gpio_pins_2_o_oval), 32'(tbl[i].done));
      chk($sformatf("run_stat@%0d", tbl[i].n), 32'(io_gpio_pins_1_o_oval), 32'(tbl[i].status));
    end

    // JTAG: IR capture, BYPASS one-stage delay, TMS reset, IDCODE, TRSTn
    repeat (5) tck_pulse(1'b1, 1'b0);
    chk("jtag_tdo_tlr", 32'(io_jtag_TDO), 32'd0);
    tck_pulse(1'b0, 1'b0);
    load_ir_bypass(got);
    chk("jtag_ir_capture", got, 32'h1);
    go_shift_dr();
    shift_read(9, 32'h0C5, got);
    chk("jtag_bypass_c5", got, 32'h18A);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    repeat (5) tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    go_shift_dr();
    shift_read(32, 32'h0, got);
    chk("jtag_idcode", got, 32'h0000_194B);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);
    chk("jtag_tdo_rti", 32'(io_jtag_TDO), 32'd0);
    load_ir_bypass(got);
    io_jtag_TRSTn = 1'b0;
    repeat (3) @(negedge clock);
    io_jtag_TRSTn = 1'b1;
    tck_pulse(1'b0, 1'b0);
    go_shift_dr();
    shift_read(8, 32'h0, got);
    chk("jtag_trst_idcode", got, 32'h4B);
    tck_pulse(1'b1, 1'b0);
    tck_pulse(1'b0, 1'b0);

    // Tone ignores gfskout: every 1-bit decodes as 0, 16 errors
    tone_fixed = 1'b1;
    do_reset(5);
    wait_rel(100);
    chk("fixed_gfsk_100", 32'(io_gfskout), 32'd1);
    check_end("fixed", 1'b0);
    tone_fixed = 1'b0;

    // Error threshold: 2 corrupted 1-bit windows pass, 3 fail
    corrupt = 32'h0000_0005;
    do_reset(5);
    check_end("err2", 1'b1);
    corrupt = 32'h0000_0025;
    do_reset(5);
    check_end("err3", 1'b0);
    corrupt = 32'h0;

    // Modulator bypass during TX
    do_reset(5);
    wait_rel(120);
    io_modulator_bypass_force = 1'b1;
    wait_rel(121);
    chk("byp_lo_121", 32'(io_gfskout), 32'd1);
    wait_rel(128);
    chk("byp_lo_128", 32'(io_gfskout), 32'd1);
    io_modulator_bypass_force = 1'b0;
    wait_rel(129);
    chk("byp_release_7", 32'(io_gfskout), 32'd7);
    wait_rel(180);
    io_alternate_modulation_in = 1'b1;
    io_modulator_bypass_force  = 1'b1;
    for (int c = 181; c <= 185; c++) begin
      wait_rel(c);
      chk($sformatf("byp_hi@%0d", c), 32'(io_gfskout), 32'd7);
    end
    io_modulator_bypass_force  = 1'b0;
    io_alternate_modulation_in = 1'b0;
    wait_rel(186);
    chk("byp_release_1", 32'(io_gfskout), 32'd1);
    check_end("byp", 1'b1);

    // Reset in the middle of transmission, then a clean rerun
    do_reset(5);
    wait_rel(999);
    chk("midtx_active", 32'(io_gfskout != 3'd0), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("midtx_gfsk", 32'(io_gfskout), 32'd0);
    chk("midtx_done", 32'(io_gpio_pins_2_o_oval), 32'd0);
    chk("midtx_stat", 32'(io_gpio_pins_1_o_oval), 32'd0);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    wait_rel(99);
    chk("rerun_gfsk_99", 32'(io_gfskout), 32'd0);
    wait_rel(100);
    chk("rerun_gfsk_100", 32'(io_gfskout), 32'd1);
    check_end("rerun", 1'b1);
    chk("end_txd", 32'(io_uart_txd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
